// File: rtl/dsn_seq_tmb.sv
// dsn_seq_tmb: sequences a 1-wire serial-number read (init, Read-ROM, 64 read slots)
// through the DSN bit engine and checks the Dallas CRC-8 of the result.
module dsn_seq_tmb #(
   parameter int          MXTO    = 18,
   parameter logic [7:0]  ROM_CMD = 8'h33,
   parameter int          GAP     = 2
) (
   input  logic        clock,
   input  logic        global_reset_n,
   input  logic        dsn_start,
   output logic        bit_start,
   output logic        bit_wr_data,
   output logic        bit_wr_init,
   input  logic        bit_busy,
   input  logic        bit_rd_data,
   output logic        dsn_busy,
   output logic        dsn_done,
   output logic        dsn_err,
   output logic        dsn_crc_ok,
   output logic [63:0] dsn_sn
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_WRCMD = 3'd2;
   localparam logic [2:0] S_RDSN  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;
   localparam logic [1:0] B_ASSERT = 2'd0;
   localparam logic [1:0] B_WBUSY  = 2'd1;
   localparam logic [1:0] B_WDONE  = 2'd2;
   localparam logic [1:0] B_GAP    = 2'd3;
   localparam int GW = $clog2(GAP + 1);
   localparam logic [MXTO-1:0] TO_ONE  = 1;
   localparam logic [GW-1:0]   GAP_ONE = 1;
   localparam logic [GW-1:0]   GAP_END = GW'(GAP - 1);

   logic [2:0]      r_sm;
   logic [1:0]      r_bs;
   logic [6:0]      r_cnt;
   logic [MXTO-1:0] r_to;
   logic [GW-1:0]   r_gap;
   logic [7:0]      r_crc;
   logic            r_start_ff;
   logic            w_edge;
   logic            w_fb;
   logic            w_last;
   logic            w_timeout;

   assign w_edge      = dsn_start & ~r_start_ff;
   assign w_fb        = r_crc[0] ^ bit_rd_data;
   assign w_timeout   = (r_bs == B_WBUSY || r_bs == B_WDONE) && (&r_to);
   assign w_last      = (r_sm == S_INIT) || (r_sm == S_WRCMD && r_cnt == 7'd8) ||
                        (r_sm == S_RDSN && r_cnt == 7'd64);
   assign dsn_busy    = (r_sm == S_INIT) || (r_sm == S_WRCMD) || (r_sm == S_RDSN);
   assign bit_start   = dsn_busy && (r_bs != B_GAP);
   assign bit_wr_init = (r_sm == S_INIT);
   assign bit_wr_data = (r_sm == S_WRCMD) ? ROM_CMD[r_cnt[2:0]] : (r_sm == S_INIT || r_sm == S_RDSN);
   assign dsn_done    = (r_sm == S_DONE);
   assign dsn_err     = (r_sm == S_ERR);
   assign dsn_crc_ok  = dsn_done && (r_crc == 8'h00);

   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         r_sm       <= S_IDLE;
         r_bs       <= B_ASSERT;
         r_cnt      <= '0;
         r_to       <= '0;
         r_gap      <= '0;
         r_crc      <= '0;
         r_start_ff <= 1'b0;
         dsn_sn     <= '0;
      end else begin
         r_start_ff <= dsn_start;
         if (!dsn_busy) begin
            if (w_edge) begin
               r_sm  <= S_INIT;
               r_bs  <= B_ASSERT;
               r_cnt <= '0;
               r_crc <= '0;
            end
         end else if (w_timeout) begin
            r_sm <= S_ERR;
            r_bs <= B_ASSERT;
         end else begin
            case (r_bs)
               B_ASSERT: begin
                  r_to <= '0;
                  r_bs <= B_WBUSY;
               end
               B_WBUSY: begin
                  r_to <= r_to + TO_ONE;
                  if (bit_busy) r_bs <= B_WDONE;
               end
               B_WDONE: begin
                  r_to <= r_to + TO_ONE;
                  // busy low again means the engine has finished the slot and sits in unstart
                  if (!bit_busy) begin
                     r_bs  <= B_GAP;
                     r_gap <= '0;
                     r_cnt <= r_cnt + 7'd1;
                     if (r_sm == S_RDSN) begin
                        dsn_sn <= {bit_rd_data, dsn_sn[63:1]};
                        r_crc  <= {w_fb, r_crc[7:1]} ^ (w_fb ? 8'h0C : 8'h00);
                     end
                  end
               end
               default: begin
                  if (r_gap != GAP_END) r_gap <= r_gap + GAP_ONE;
                  else begin
                     r_bs <= B_ASSERT;
                     if (w_last) begin
                        r_cnt <= '0;
                        r_sm  <= (r_sm == S_INIT) ? S_WRCMD : (r_sm == S_WRCMD) ? S_RDSN : S_DONE;
                     end
                  end
               end
            endcase
         end
      end
   end
endmodule
